ysyx_25060170_lsu_wb: RTL
=========================

// Module: ysyx_25060170_lsu_wb
// PURPOSE
//  Load/store + write-back stage; sits between EXU and the GPR file.
//  Replaces combinational DPI memory access with a valid/ready memory bus.
//  Aligns store lanes, sign/zero-extends loads, picks the write-back source and
//  drives one registered GPR write per instruction. Times out stuck accesses.
// PARAMETERS
//  XLEN        32   datapath width; 32 or 64 (SIZE=3 legal only when 64)
//  REG_AW      5    GPR address width
//  TIMEOUT_CYC 255  max cycles in REQ+WAIT before abort; 0 disables timeout
// PORTS
//  clk        in   1         clock, rising edge
//  rst        in   1         asynchronous, active-high reset
//  in_valid   in   1         EXU presents an instruction
//  in_ready   out  1         block can accept (high only in IDLE and !rst)
//  exu_result in   XLEN      ALU result / effective address
//  pc         in   XLEN      instruction PC
//  rd         in   REG_AW    destination register
//  wb_sel     in   2         0 ALU, 1 load data, 2 pc+4, 3 reserved (writes 0)
//  reg_we     in   1         GPR write enable
//  mem_rd     in   1         load
//  mem_wr     in   1         store (mem_rd&mem_wr: treated as store)
//  mem_size   in   2         0 byte, 1 half, 2 word, 3 dword
//  mem_uns    in   1         load zero-extend when 1
//  store_data in   XLEN      rs2 value
//  req_valid  out  1         memory request
//  req_ready  in   1         memory accepts request
//  req_wen    out  1         1 write, 0 read
//  req_addr   out  XLEN      address, low log2(XLEN/8) bits forced to 0
//  req_wdata  out  XLEN      lane-shifted store data
//  req_wstrb  out  XLEN/8    byte strobes (all 0 on read)
//  resp_valid in   1         read data / write ack
//  resp_rdata in   XLEN      read data (full aligned word)
//  wb_en      out  1         GPR write strobe, 1 cycle
//  wb_addr    out  REG_AW    GPR write address
//  wb_data    out  XLEN      GPR write data
//  done       out  1         instruction retired, 1 cycle (advance PC)
//  err        out  1         misaligned or timeout, 1 cycle, with done
// BEHAVIOUR
//  Reset: state=IDLE; req_* , wb_*, done, err, timeout counter = 0.
//  States: IDLE, REQ, WAIT, WB.
//  IDLE: on in_valid, latch all inputs. Misaligned (addr not multiple of 2^size)
//   or illegal size -> WB with err. No memory op -> WB. Otherwise -> REQ.
//  REQ: req_valid=1, request fields held stable until req_ready; then -> WAIT.
//   Same-cycle resp_valid with req_ready is legal -> WB directly.
//  WAIT: on resp_valid, register the extended load data -> WB. Responses
//   outside WAIT (or the REQ accept cycle) are ignored.
//  WB (1 cycle): done=1. wb_en=reg_we & !err & rd!=0. Back to IDLE.
//  Latency: non-memory op accepted at cycle N -> wb_en/done at N+1.
//   Memory op with 0-wait memory -> done at N+3.
//  Store lanes: off=addr[lsb]; wdata=store_data<<(8*off); wstrb=mask(size)<<off.
//  Load: lane=resp_rdata>>(8*off); trunc to size; sign-extend unless mem_uns.
//  wb_data: sel0 exu_result; sel1 load data; sel2 pc+4 (mod 2^XLEN); sel3 0.
//  Timeout: counter clears on REQ entry, increments each REQ/WAIT cycle. At
//   TIMEOUT_CYC -> WB with err, req_valid dropped. A late resp_valid is ignored.
//  Async rst mid-access: everything returns to reset values at once. The
//   in-flight instruction is lost. Memory side must tolerate req_valid dropping.
// TESTING
//  ALU op rd=5 wb_sel=0 exu_result=0x1234 -> next cycle wb_en=1 addr=5 data=0x1234 done=1
//  lb addr=0x80000003 rdata=0x80FF_0000 -> wb_data=0xFFFFFF80; lbu -> 0x00000080
//  sh addr=0x2 data=0xABCD -> req_wdata=0xABCD0000 wstrb=4'b1100 wen=1; wb_en=0
//  lw addr=0x6 -> no req_valid; next cycle done=1 err=1 wb_en=0
//  TIMEOUT_CYC=4, req_ready held 0 -> err+done 4 cycles after REQ entry
//  jal rd=1 pc=0xFFFFFFFC wb_sel=2 -> wb_data=0x0; rd=0 -> wb_en=0, done=1

Source files
------------

// File: rtl/ysyx_25060170_lsu_wb.sv
// Load/store + write-back stage between EXU and the GPR file: drives a valid/ready
// memory bus, aligns store lanes, extends loads and issues one GPR write per instruction.
module ysyx_25060170_lsu_wb #(
    parameter int XLEN        = 32,
    parameter int REG_AW      = 5,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [XLEN-1:0]     exu_result,
    input  logic [XLEN-1:0]     pc,
    input  logic [REG_AW-1:0]   rd,
    input  logic [1:0]          wb_sel,
    input  logic                reg_we,
    input  logic                mem_rd,
    input  logic                mem_wr,
    input  logic [1:0]          mem_size,
    input  logic                mem_uns,
    input  logic [XLEN-1:0]     store_data,
    output logic                req_valid,
    input  logic                req_ready,
    output logic                req_wen,
    output logic [XLEN-1:0]     req_addr,
    output logic [XLEN-1:0]     req_wdata,
    output logic [XLEN/8-1:0]   req_wstrb,
    input  logic                resp_valid,
    input  logic [XLEN-1:0]     resp_rdata,
    output logic                wb_en,
    output logic [REG_AW-1:0]   wb_addr,
    output logic [XLEN-1:0]     wb_data,
    output logic                done,
    output logic                err
);
    localparam int STRB = XLEN / 8;
    localparam int LSB  = $clog2(STRB);
    localparam int CW   = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
    localparam logic [CW-1:0] TMO_LAST = (TIMEOUT_CYC > 0) ? CW'(TIMEOUT_CYC - 1) : '0;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;
    localparam logic [1:0] S_WB   = 2'd3;

    logic [1:0]        state;
    logic [CW-1:0]     tmo_cnt;

    logic [XLEN-1:0]   l_result;
    logic [XLEN-1:0]   l_pc;
    logic [REG_AW-1:0] l_rd;
    logic [1:0]        l_sel;
    logic [1:0]        l_size;
    logic              l_we;
    logic              l_load;
    logic              l_uns;
    logic [LSB-1:0]    l_off;

    function automatic logic [2:0] align_mask(input logic [1:0] size);
        case (size)
            2'd0:    align_mask = 3'b000;
            2'd1:    align_mask = 3'b001;
            2'd2:    align_mask = 3'b011;
            default: align_mask = 3'b111;
        endcase
    endfunction

    function automatic logic [7:0] byte_mask(input logic [1:0] size);
        case (size)
            2'd0:    byte_mask = 8'h01;
            2'd1:    byte_mask = 8'h03;
            2'd2:    byte_mask = 8'h0F;
            default: byte_mask = 8'hFF;
        endcase
    endfunction

    function automatic logic [XLEN-1:0] pick_wb(input logic [1:0] sel,
                                                input logic [XLEN-1:0] alu,
                                                input logic [XLEN-1:0] pcv,
                                                input logic [XLEN-1:0] ld);
        case (sel)
            2'd0:    pick_wb = alu;
            2'd1:    pick_wb = ld;
            2'd2:    pick_wb = pcv + XLEN'(4);
            default: pick_wb = '0;
        endcase
    endfunction

    logic [LSB-1:0]  in_off;
    logic            in_mem;
    logic            bad_access;
    logic [STRB-1:0] in_strb;
    logic [XLEN-1:0] in_wdata;
    logic [XLEN-1:0] in_aligned;

    always_comb begin
        in_off     = exu_result[LSB-1:0];
        in_mem     = mem_rd | mem_wr;
        bad_access = ((mem_size == 2'd3) && (XLEN == 32)) ||
                     (|(exu_result[2:0] & align_mask(mem_size)));
        in_strb    = STRB'(byte_mask(mem_size)) << in_off;
        in_wdata   = store_data << {in_off, 3'b000};
        in_aligned = {exu_result[XLEN-1:LSB], {LSB{1'b0}}};
    end

    // Shift the addressed lane up to the MSB, then back down arithmetically or logically.
    logic [XLEN-1:0] lane;
    logic [XLEN-1:0] lane_up;
    logic [6:0]      ext_sh;
    logic [XLEN-1:0] load_ext;

    always_comb begin
        lane     = resp_rdata >> {l_off, 3'b000};
        ext_sh   = 7'(XLEN) - (7'd8 << l_size);
        lane_up  = lane << ext_sh;
        load_ext = l_uns ? (lane_up >> ext_sh) : XLEN'($signed(lane_up) >>> ext_sh);
    end

    logic in_access;
    logic finish_ok;
    logic timed_out;

    always_comb begin
        in_access = (state == S_REQ) || (state == S_WAIT);
        finish_ok = ((state == S_REQ) && req_ready && resp_valid) ||
                    ((state == S_WAIT) && resp_valid);
        timed_out = (TIMEOUT_CYC != 0) && in_access && (tmo_cnt == TMO_LAST);
    end

    assign in_ready = (state == S_IDLE) && !rst;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            tmo_cnt   <= '0;
            l_result  <= '0;
            l_pc      <= '0;
            l_rd      <= '0;
            l_sel     <= '0;
            l_size    <= '0;
            l_we      <= 1'b0;
            l_load    <= 1'b0;
            l_uns     <= 1'b0;
            l_off     <= '0;
            req_valid <= 1'b0;
            req_wen   <= 1'b0;
            req_addr  <= '0;
            req_wdata <= '0;
            req_wstrb <= '0;
            wb_en     <= 1'b0;
            wb_addr   <= '0;
            wb_data   <= '0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        l_result <= exu_result;
                        l_pc     <= pc;
                        l_rd     <= rd;
                        l_sel    <= wb_sel;
                        l_size   <= mem_size;
                        l_we     <= reg_we;
                        l_load   <= mem_rd & ~mem_wr;
                        l_uns    <= mem_uns;
                        l_off    <= in_off;
                        wb_addr  <= rd;
                        if (!in_mem || bad_access) begin
                            state   <= S_WB;
                            done    <= 1'b1;
                            err     <= in_mem;
                            wb_en   <= !in_mem && reg_we && (rd != '0);
                            wb_data <= pick_wb(wb_sel, exu_result, pc, '0);
                        end else begin
                            state     <= S_REQ;
                            tmo_cnt   <= '0;
                            req_valid <= 1'b1;
                            req_wen   <= mem_wr;
                            req_addr  <= in_aligned;
                            req_wdata <= mem_wr ? in_wdata : '0;
                            req_wstrb <= mem_wr ? in_strb : '0;
                        end
                    end
                end
                S_REQ, S_WAIT: begin
                    // A response arriving on the final allowed cycle still wins over the timeout.
                    if (finish_ok) begin
                        state     <= S_WB;
                        req_valid <= 1'b0;
                        done      <= 1'b1;
                        wb_en     <= l_we && (l_rd != '0);
                        wb_data   <= pick_wb(l_sel, l_result, l_pc, l_load ? load_ext : '0);
                    end else if (timed_out) begin
                        state     <= S_WB;
                        req_valid <= 1'b0;
                        done      <= 1'b1;
                        err       <= 1'b1;
                        wb_en     <= 1'b0;
                        wb_data   <= pick_wb(l_sel, l_result, l_pc, '0);
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                        if ((state == S_REQ) && req_ready) begin
                            req_valid <= 1'b0;
                            state     <= S_WAIT;
                        end
                    end
                end
                S_WB: begin
                    state <= S_IDLE;
                    done  <= 1'b0;
                    err   <= 1'b0;
                    wb_en <= 1'b0;
                end
            endcase
        end
    end
endmodule
